// File: rtl/avalon_csr_pkg.sv
// Shared types and helpers for the Avalon-MM CSR bank: FSM state, word-offset
// helpers and the byte-lane merge used by every writable register.
package avalon_csr_pkg;

  typedef enum logic {ST_INIT, ST_READY} state_t;

  // Word map: RW block from 0, RO block follows, then the two interrupt words.
  localparam int unsigned RW_BASE = 0;

  function automatic int unsigned ro_base(int unsigned num_rw);
    return RW_BASE + num_rw;
  endfunction

  function automatic int unsigned irq_status_word(int unsigned num_rw, int unsigned num_ro);
    return RW_BASE + num_rw + num_ro;
  endfunction

  function automatic int unsigned irq_mask_word(int unsigned num_rw, int unsigned num_ro);
    return RW_BASE + num_rw + num_ro + 1;
  endfunction

  function automatic logic [7:0] merge_lane(logic [7:0] old_b, logic [7:0] new_b, logic en);
    return en ? new_b : old_b;
  endfunction

endpackage

// File: rtl/avalon_csr_irq.sv
// Sticky interrupt status (W1C, set wins over clear) with a byte-writable mask
// and a registered level interrupt.
module avalon_csr_irq
  import avalon_csr_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              avalon_clk,
  input  logic              reset_n,
  input  logic              wr_status,
  input  logic              wr_mask,
  input  logic [DATA_W-1:0] writedata,
  input  logic [DATA_W/8-1:0] byteenable,
  input  logic [DATA_W-1:0] event_in,
  output logic [DATA_W-1:0] status_q,
  output logic [DATA_W-1:0] mask_q,
  output logic              irq
);

  logic [DATA_W-1:0] clr_p0;

  always_comb begin
    clr_p0 = '0;
    for (int b = 0; b < DATA_W/8; b++) begin
      if (wr_status && byteenable[b]) clr_p0[b*8 +: 8] = writedata[b*8 +: 8];
    end
  end

  always_ff @(posedge avalon_clk or negedge reset_n) begin
    if (!reset_n) begin
      status_q <= '0;
      mask_q   <= '0;
      irq      <= 1'b0;
    end else begin
      status_q <= (status_q & ~clr_p0) | event_in;
      if (wr_mask) begin
        for (int b = 0; b < DATA_W/8; b++) begin
          mask_q[b*8 +: 8] <= merge_lane(mask_q[b*8 +: 8], writedata[b*8 +: 8], byteenable[b]);
        end
      end
      // Built from the registered status, so irq trails status by one cycle.
      irq <= |(status_q & mask_q);
    end
  end

endmodule

// File: rtl/avalon_csr_bank.sv
// Avalon-MM slave CSR bank: NUM_RW byte-writable control words, NUM_RO status
// shadows, 1-cycle read latency. Interrupt block included when AVS_IRQ_EN is defined.
module avalon_csr_bank
  import avalon_csr_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int NUM_RW = 5,
  parameter int NUM_RO = 3
) (
  input  logic                     avalon_clk,
  input  logic                     reset_n,
  input  logic                     chipselect,
  input  logic [ADDR_W-1:0]        address,
  input  logic                     write,
  input  logic [DATA_W-1:0]        writedata,
  input  logic [DATA_W/8-1:0]      byteenable,
  input  logic                     read,
  output logic [DATA_W-1:0]        readdata,
  output logic                     readdatavalid,
  output logic                     waitrequest,
  output logic [NUM_RW*DATA_W-1:0] ctrl_q,
  input  logic [NUM_RO*DATA_W-1:0] stat_d
`ifdef AVS_IRQ_EN
  ,
  input  logic [DATA_W-1:0]        event_in,
  output logic                     irq
`endif
);

  localparam int unsigned RO_BASE = ro_base(NUM_RW);

  state_t            state;
  logic              init_cnt;
  logic              wr_acc_p0;
  logic              rd_acc_p0;
  logic [31:0]       addr_word;
  logic [DATA_W-1:0] rd_word_p0;
  logic [DATA_W-1:0] rw_q [NUM_RW];
  logic [DATA_W-1:0] ro_q [NUM_RO];

  always_ff @(posedge avalon_clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_INIT;
      init_cnt    <= 1'b0;
      waitrequest <= 1'b1;
    end else begin
      case (state)
        ST_INIT: begin
          if (init_cnt) begin
            state       <= ST_READY;
            waitrequest <= 1'b0;
          end else begin
            init_cnt <= 1'b1;
          end
        end
        default: waitrequest <= 1'b0;
      endcase
    end
  end

  assign wr_acc_p0 = chipselect && !waitrequest && write;
  assign rd_acc_p0 = chipselect && !waitrequest && read;
  assign addr_word = 32'(address);

  always_ff @(posedge avalon_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_RW; i++) rw_q[i] <= '0;
      for (int i = 0; i < NUM_RO; i++) ro_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_RW; i++) begin
        if (wr_acc_p0 && addr_word == RW_BASE + i) begin
          for (int b = 0; b < DATA_W/8; b++) begin
            rw_q[i][b*8 +: 8] <= merge_lane(rw_q[i][b*8 +: 8], writedata[b*8 +: 8], byteenable[b]);
          end
        end
      end
      for (int i = 0; i < NUM_RO; i++) ro_q[i] <= stat_d[i*DATA_W +: DATA_W];
    end
  end

  for (genvar g = 0; g < NUM_RW; g++) begin : g_ctrl
    assign ctrl_q[g*DATA_W +: DATA_W] = rw_q[g];
  end

`ifdef AVS_IRQ_EN
  localparam int unsigned IRQ_STATUS_WORD = irq_status_word(NUM_RW, NUM_RO);
  localparam int unsigned IRQ_MASK_WORD   = irq_mask_word(NUM_RW, NUM_RO);

  logic [DATA_W-1:0] irq_status;
  logic [DATA_W-1:0] irq_mask;

  avalon_csr_irq #(.DATA_W(DATA_W)) u_irq (
    .avalon_clk (avalon_clk),
    .reset_n    (reset_n),
    .wr_status  (wr_acc_p0 && addr_word == IRQ_STATUS_WORD),
    .wr_mask    (wr_acc_p0 && addr_word == IRQ_MASK_WORD),
    .writedata  (writedata),
    .byteenable (byteenable),
    .event_in   (event_in),
    .status_q   (irq_status),
    .mask_q     (irq_mask),
    .irq        (irq)
  );
`endif

  // Read mux sees pre-edge register values, so read+write to one word returns the old data.
  always_comb begin
    rd_word_p0 = '0;
    for (int i = 0; i < NUM_RW; i++) begin
      if (addr_word == RW_BASE + i) rd_word_p0 = rw_q[i];
    end
    for (int i = 0; i < NUM_RO; i++) begin
      if (addr_word == RO_BASE + i) rd_word_p0 = ro_q[i];
    end
`ifdef AVS_IRQ_EN
    if (addr_word == IRQ_STATUS_WORD) rd_word_p0 = irq_status;
    if (addr_word == IRQ_MASK_WORD)   rd_word_p0 = irq_mask;
`endif
  end

  // Stage p1: registered read response.
  always_ff @(posedge avalon_clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata      <= '0;
      readdatavalid <= 1'b0;
    end else begin
      readdatavalid <= rd_acc_p0;
      if (rd_acc_p0) readdata <= rd_word_p0;
    end
  end

endmodule

// File: tb/tb_avalon_csr_bank.sv
// Directed bench for avalon_csr_bank; interrupt checks compiled in when AVS_IRQ_EN is defined.
module tb_avalon_csr_bank;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int NUM_RW = 5;
  localparam int NUM_RO = 3;

  logic                     avalon_clk;
  logic                     reset_n;
  logic                     chipselect;
  logic [ADDR_W-1:0]        address;
  logic                     write;
  logic [DATA_W-1:0]        writedata;
  logic [DATA_W/8-1:0]      byteenable;
  logic                     read;
  logic [DATA_W-1:0]        readdata;
  logic                     readdatavalid;
  logic                     waitrequest;
  logic [NUM_RW*DATA_W-1:0] ctrl_q;
  logic [NUM_RO*DATA_W-1:0] stat_d;
`ifdef AVS_IRQ_EN
  logic [DATA_W-1:0]        event_in;
  logic                     irq;
`endif

  int checks   = 0;
  int failures = 0;

  avalon_csr_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RW(NUM_RW), .NUM_RO(NUM_RO)) dut (
    .avalon_clk    (avalon_clk),
    .reset_n       (reset_n),
    .chipselect    (chipselect),
    .address       (address),
    .write         (write),
    .writedata     (writedata),
    .byteenable    (byteenable),
    .read          (read),
    .readdata      (readdata),
    .readdatavalid (readdatavalid),
    .waitrequest   (waitrequest),
    .ctrl_q        (ctrl_q),
    .stat_d        (stat_d)
`ifdef AVS_IRQ_EN
    ,
    .event_in      (event_in),
    .irq           (irq)
`endif
  );

  initial avalon_clk = 1'b0;
  always #5 avalon_clk = ~avalon_clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ctrl(input int i);
    return ctrl_q[i*DATA_W +: DATA_W];
  endfunction

  task automatic idle();
    chipselect = 1'b0;
    write      = 1'b0;
    read       = 1'b0;
    byteenable = '0;
  endtask

  task automatic bus_write(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge avalon_clk);
    chipselect = 1'b1; write = 1'b1; read = 1'b0;
    address = a; writedata = d; byteenable = be;
    @(negedge avalon_clk);
    idle();
  endtask

  task automatic bus_read(input logic [ADDR_W-1:0] a, output logic [31:0] d, output logic v);
    @(negedge avalon_clk);
    chipselect = 1'b1; read = 1'b1; write = 1'b0; address = a;
    @(negedge avalon_clk);
    idle();
    v = readdatavalid;
    d = readdata;
  endtask

  logic [31:0] rd;
  logic        vld;
  logic        seen;

  initial begin
    reset_n = 1'b0;
    idle();
    address = '0; writedata = '0; stat_d = '0;
`ifdef AVS_IRQ_EN
    event_in = '0;
`endif
    repeat (3) @(negedge avalon_clk);
    check("rst_wait", 32'(waitrequest), 32'd1);
    check("rst_rdv", 32'(readdatavalid), 32'd0);
    check("rst_rdata", readdata, 32'h0);
    for (int i = 0; i < NUM_RW; i++) check($sformatf("rst_ctrl%0d", i), ctrl(i), 32'h0);
`ifdef AVS_IRQ_EN
    check("rst_irq", 32'(irq), 32'd0);
`endif

    // Release; a write held during the two wait cycles must be ignored.
    reset_n = 1'b1;
    chipselect = 1'b1; write = 1'b1; address = 4'd3; writedata = 32'hDEADBEEF; byteenable = 4'hF;
    check("wait_rel", 32'(waitrequest), 32'd1);
    @(posedge avalon_clk); #1;
    check("wait_c1", 32'(waitrequest), 32'd1);
    @(posedge avalon_clk); #1;
    idle();
    check("wait_c2", 32'(waitrequest), 32'd0);
    @(negedge avalon_clk);
    check("wait_write_ignored", ctrl(3), 32'h0);
    check("wait_ready", 32'(waitrequest), 32'd0);

    bus_read(4'd0, rd, vld);
    check("rd0_vld", 32'(vld), 32'd1);
    check("rd0_data", rd, 32'h0);
    @(negedge avalon_clk);
    check("rd0_vld_drop", 32'(readdatavalid), 32'd0);

    bus_write(4'd1, 32'hAABBCCDD, 4'b0101);
    check("be_lanes", ctrl(1), 32'h00BB00DD);
    bus_write(4'd0, 32'h11111111, 4'hF);
    bus_write(4'd2, 32'h33333333, 4'hF);
    check("wr0", ctrl(0), 32'h11111111);
    check("wr2", ctrl(2), 32'h33333333);

    // Back-to-back reads of words 0,1,2.
    @(negedge avalon_clk);
    chipselect = 1'b1; read = 1'b1; address = 4'd0;
    @(negedge avalon_clk);
    check("b2b0_vld", 32'(readdatavalid), 32'd1);
    check("b2b0_data", readdata, 32'h11111111);
    address = 4'd1;
    @(negedge avalon_clk);
    check("b2b1_vld", 32'(readdatavalid), 32'd1);
    check("b2b1_data", readdata, 32'h00BB00DD);
    address = 4'd2;
    @(negedge avalon_clk);
    idle();
    check("b2b2_vld", 32'(readdatavalid), 32'd1);
    check("b2b2_data", readdata, 32'h33333333);
    @(negedge avalon_clk);
    check("b2b_end_vld", 32'(readdatavalid), 32'd0);
    check("rdata_hold", readdata, 32'h33333333);

    // RO words ignore writes and track stat_d.
    stat_d[31:0]  = 32'h12345678;
    stat_d[63:32] = 32'hCAFEF00D;
    bus_write(4'd5, 32'hFFFFFFFF, 4'hF);
    bus_read(4'd5, rd, vld);
    check("ro5_data", rd, 32'h12345678);
    bus_read(4'd6, rd, vld);
    check("ro6_data", rd, 32'hCAFEF00D);
    check("ro_write_no_ctrl", ctrl(4), 32'h0);

    // Read and write the same word together: old value returned, write lands.
    @(negedge avalon_clk);
    chipselect = 1'b1; read = 1'b1; write = 1'b1;
    address = 4'd0; writedata = 32'h5A5A5A5A; byteenable = 4'hF;
    @(negedge avalon_clk);
    idle();
    check("rw_same_vld", 32'(readdatavalid), 32'd1);
    check("rw_same_old", readdata, 32'h11111111);
    check("rw_same_new", ctrl(0), 32'h5A5A5A5A);

    bus_write(4'd15, 32'hFFFFFFFF, 4'hF);
    bus_read(4'd15, rd, vld);
    check("unmapped_vld", 32'(vld), 32'd1);
    check("unmapped_data", rd, 32'h0);

`ifdef AVS_IRQ_EN
    bus_write(4'd9, 32'h1, 4'hF);
    bus_read(4'd9, rd, vld);
    check("irq_mask_rd", rd, 32'h1);
    check("irq_idle", 32'(irq), 32'd0);
    @(negedge avalon_clk);
    event_in = 32'h1;
    @(negedge avalon_clk);
    event_in = 32'h0;
    @(negedge avalon_clk);
    check("irq_set", 32'(irq), 32'd1);
    bus_read(4'd8, rd, vld);
    check("irq_status_rd", rd, 32'h1);
    // Clear and a new event on the same bit in one cycle: set wins.
    @(negedge avalon_clk);
    chipselect = 1'b1; write = 1'b1; address = 4'd8; writedata = 32'h1; byteenable = 4'hF;
    event_in = 32'h1;
    @(negedge avalon_clk);
    idle();
    event_in = 32'h0;
    bus_read(4'd8, rd, vld);
    check("irq_set_wins", rd, 32'h1);
    check("irq_still", 32'(irq), 32'd1);
    @(negedge avalon_clk);
    chipselect = 1'b1; write = 1'b1; address = 4'd8; writedata = 32'h1; byteenable = 4'hF;
    @(negedge avalon_clk);
    idle();
    check("irq_lag", 32'(irq), 32'd1);
    @(negedge avalon_clk);
    check("irq_cleared", 32'(irq), 32'd0);
    bus_read(4'd8, rd, vld);
    check("irq_status_clr", rd, 32'h0);
`else
    bus_write(4'd8, 32'hFFFFFFFF, 4'hF);
    bus_write(4'd9, 32'hFFFFFFFF, 4'hF);
    bus_read(4'd8, rd, vld);
    check("nirq_status_rd", rd, 32'h0);
    bus_read(4'd9, rd, vld);
    check("nirq_mask_rd", rd, 32'h0);
`endif

    // Reset right after an accepted read.
    bus_write(4'd3, 32'h44444444, 4'hF);
    check("wr3", ctrl(3), 32'h44444444);
    @(negedge avalon_clk);
    chipselect = 1'b1; read = 1'b1; address = 4'd3;
    @(posedge avalon_clk); #1;
    reset_n = 1'b0;
    idle();
    #1;
    check("mid_rst_rdv", 32'(readdatavalid), 32'd0);
    check("mid_rst_rdata", readdata, 32'h0);
    check("mid_rst_wait", 32'(waitrequest), 32'd1);
    for (int i = 0; i < NUM_RW; i++) check($sformatf("mid_rst_ctrl%0d", i), ctrl(i), 32'h0);
    @(negedge avalon_clk);
    reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge avalon_clk);
      seen = seen | readdatavalid;
    end
    check("post_rst_no_rdv", 32'(seen), 32'd0);
    check("post_rst_ready", 32'(waitrequest), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
